// File: rtl/mv_collector_pkg.sv
// mv_collector_pkg: shared frame geometry defaults, field widths and FSM state encodings
// for the motion-vector result collector.
package mv_collector_pkg;
   localparam int BLK_COLS_DEF = 480;
   localparam int BLK_ROWS_DEF = 270;
   localparam int SAD_W        = 14;
   localparam int MV_W         = 4;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/mv_collector_fifo.sv
// mv_collector_fifo: synchronous show-ahead FIFO; the caller only pushes when not full or
// when popping in the same cycle, so a full FIFO can still take a push alongside a pop.
module mv_collector_fifo #(
   parameter int WIDTH = 41,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, rd_q;
   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty_o = wr_q == rd_q;
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign data_o  = mem_q[rd_q[AW-1:0]];
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_q + (AW+1)'(push_i);
         rd_q <= rd_q + (AW+1)'(pop_i);
      end
   end
endmodule

// File: rtl/mv_collector.sv
// mv_collector: captures one SAD/motion-vector result per search slot, tags it with its 8x8
// block coordinate, buffers it and hands it to write-back over valid/ready.
module mv_collector
   import mv_collector_pkg::*;
#(
   parameter int BLK_COLS   = BLK_COLS_DEF,
   parameter int BLK_ROWS   = BLK_ROWS_DEF,
   parameter int FIFO_DEPTH = 8,
   parameter int X_W        = 9,
   parameter int Y_W        = 9
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  frame_start_i,
   input  logic                                  sad_en_i,
   input  logic [SAD_W-1:0]                      sad_min_i,
   input  logic [MV_W-1:0]                       mv_x_i,
   input  logic [MV_W-1:0]                       mv_y_i,
   output logic                                  mv_valid_o,
   input  logic                                  mv_ready_i,
   output logic [1+Y_W+X_W+2*MV_W+SAD_W-1:0]     mv_data_o,
   output logic                                  frame_done_o,
   output logic                                  ovf_o,
   output logic                                  busy_o
);
   localparam int DW = 1 + Y_W + X_W + 2*MV_W + SAD_W;
   logic [0:0]     state_q, state_d;
   logic [X_W-1:0] blk_x_q, blk_x_d;
   logic [Y_W-1:0] blk_y_q, blk_y_d;
   logic           skip_q, sad_en_d_q, ovf_q, ovf_d, done_q;
   logic           x_end, last, wr, pop, push, full, empty;
   logic [DW-1:0]  rec, head;
   always_comb begin
      x_end   = blk_x_q == X_W'(BLK_COLS-1);
      last    = x_end && (blk_y_q == Y_W'(BLK_ROWS-1));
      // A capture colliding with frame_start belongs to no frame and is discarded.
      wr      = sad_en_d_q && state_q == ST_RUN && !frame_start_i;
      pop     = mv_valid_o && mv_ready_i;
      push    = wr && (!full || pop);
      rec     = {last, blk_y_q, blk_x_q, mv_y_i, mv_x_i, sad_min_i};
      state_d = frame_start_i ? ST_RUN : (wr && last) ? ST_IDLE : state_q;
      blk_x_d = frame_start_i ? '0 : !wr ? blk_x_q : x_end ? '0 : blk_x_q + 1'b1;
      blk_y_d = frame_start_i ? '0 : !wr ? blk_y_q : last ? '0 : x_end ? blk_y_q + 1'b1 : blk_y_q;
      ovf_d   = frame_start_i ? 1'b0 : ovf_q | (wr && !push);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         blk_x_q    <= '0;
         blk_y_q    <= '0;
         skip_q     <= 1'b1;
         sad_en_d_q <= 1'b0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         blk_x_q    <= blk_x_d;
         blk_y_q    <= blk_y_d;
         skip_q     <= skip_q && !sad_en_i;
         sad_en_d_q <= sad_en_i && !skip_q;
         ovf_q      <= ovf_d;
         done_q     <= wr && last;
      end
   end
   mv_collector_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (rec),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );
   assign mv_valid_o   = !empty;
   assign mv_data_o    = mv_valid_o ? head : '0;
   assign frame_done_o = done_q;
   assign ovf_o        = ovf_q;
   assign busy_o       = state_q == ST_RUN;
endmodule

// File: tb/tb_mv_collector.sv
// tb_mv_collector: directed table-driven bench for mv_collector on a 4x2-block frame.
module tb_mv_collector;
   logic        clk = 1'b0, rst_n = 1'b0, frame_start_i = 1'b0, sad_en_i = 1'b0, mv_ready_i = 1'b0;
   logic [13:0] sad_min_i = '0;
   logic [3:0]  mv_x_i = '0, mv_y_i = '0;
   logic        mv_valid_o, frame_done_o, ovf_o, busy_o;
   logic [40:0] mv_data_o;
   int          checks = 0, failures = 0, done_cnt = 0;
   logic        seen;
   typedef struct {
      logic [13:0] sad;
      logic [3:0]  mx, my;
      logic [8:0]  ex, ey;
      logic        last;
   } vec_t;
   vec_t tv [8];

   always #5 clk = ~clk;
   always @(negedge clk) if (frame_done_o) done_cnt++;

   mv_collector #(.BLK_COLS(4), .BLK_ROWS(2), .FIFO_DEPTH(8), .X_W(9), .Y_W(9)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start_i), .sad_en_i(sad_en_i),
      .sad_min_i(sad_min_i), .mv_x_i(mv_x_i), .mv_y_i(mv_y_i), .mv_valid_o(mv_valid_o),
      .mv_ready_i(mv_ready_i), .mv_data_o(mv_data_o), .frame_done_o(frame_done_o),
      .ovf_o(ovf_o), .busy_o(busy_o));

   function automatic logic [40:0] rec(input logic l, input logic [8:0] y, input logic [8:0] x,
                                       input logic [3:0] my, input logic [3:0] mx, input logic [13:0] s);
      return {l, y, x, my, mx, s};
   endfunction

   task automatic chk(input string n, input logic [40:0] act, input logic [40:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ends in the cycle two clocks after the strobe, when a fresh record first becomes visible.
   task automatic slot(input logic [13:0] s, input logic [3:0] x, input logic [3:0] y);
      sad_en_i = 1'b1; sad_min_i = s; mv_x_i = x; mv_y_i = y;
      tick();
      sad_en_i = 1'b0;
      tick();
   endtask

   task automatic fstart();
      frame_start_i = 1'b1;
      tick();
      frame_start_i = 1'b0;
   endtask

   initial begin
      tv[0] = '{14'h011, 4'h1, 4'h2, 9'd0, 9'd0, 1'b0};
      tv[1] = '{14'h022, 4'h3, 4'h4, 9'd1, 9'd0, 1'b0};
      tv[2] = '{14'h033, 4'h5, 4'h6, 9'd2, 9'd0, 1'b0};
      tv[3] = '{14'h044, 4'h7, 4'h8, 9'd3, 9'd0, 1'b0};
      tv[4] = '{14'h055, 4'h9, 4'hA, 9'd0, 9'd1, 1'b0};
      tv[5] = '{14'h066, 4'hB, 4'hC, 9'd1, 9'd1, 1'b0};
      tv[6] = '{14'h077, 4'hD, 4'hE, 9'd2, 9'd1, 1'b0};
      tv[7] = '{14'h3FFF, 4'hF, 4'h0, 9'd3, 9'd1, 1'b1};
      tick(); tick();
      chk("rst_valid", mv_valid_o, 0);
      chk("rst_data", mv_data_o, 0);
      chk("rst_done", frame_done_o, 0);
      chk("rst_ovf", ovf_o, 0);
      chk("rst_busy", busy_o, 0);
      rst_n = 1'b1;
      tick();
      seen = 1'b0;
      for (int p = 0; p < 3; p++) begin
         sad_en_i = 1'b1;
         tick();
         sad_en_i = 1'b0;
         for (int c = 0; c < 24; c++) begin
            tick();
            seen |= mv_valid_o;
         end
      end
      chk("idle_no_valid", seen, 0);
      chk("idle_ovf", ovf_o, 0);
      chk("idle_busy", busy_o, 0);
      fstart();
      mv_ready_i = 1'b1;
      sad_en_i = 1'b1; sad_min_i = 14'h123; mv_x_i = 4'd3; mv_y_i = 4'd5;
      tick();
      sad_en_i = 1'b0;
      chk("lat_t1_valid", mv_valid_o, 0);
      tick();
      chk("lat_t2_valid", mv_valid_o, 1);
      chk("lat_t2_data", mv_data_o, rec(0, 0, 0, 5, 3, 14'h123));
      chk("lat_busy", busy_o, 1);
      tick();
      chk("lat_popped", mv_valid_o, 0);
      fstart();
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         slot(tv[i].sad, tv[i].mx, tv[i].my);
         chk($sformatf("frm_valid%0d", i), mv_valid_o, 1);
         chk($sformatf("frm_data%0d", i), mv_data_o, rec(tv[i].last, tv[i].ey, tv[i].ex, tv[i].my, tv[i].mx, tv[i].sad));
         chk($sformatf("frm_done%0d", i), frame_done_o, tv[i].last);
         chk($sformatf("frm_busy%0d", i), busy_o, !tv[i].last);
         repeat (3) tick();
      end
      chk("frm_done_count", done_cnt, 1);
      chk("frm_drained", mv_valid_o, 0);
      mv_ready_i = 1'b0;
      fstart();
      for (int i = 0; i < 8; i++) begin
         slot(14'h040 + 14'(i), 4'(i), 4'(15 - i));
         tick();
      end
      chk("full_ovf0", ovf_o, 0);
      fstart();
      slot(14'h050, 4'h1, 4'h1);
      slot(14'h051, 4'h2, 4'h2);
      repeat (3) tick();
      chk("full_ovf1", ovf_o, 1);
      chk("full_busy", busy_o, 1);
      chk("full_held", mv_data_o, rec(0, 0, 0, 4'd15, 4'd0, 14'h040));
      mv_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d", i), mv_data_o,
             rec(i == 7, 9'(i / 4), 9'(i % 4), 4'(15 - i), 4'(i), 14'h040 + 14'(i)));
         tick();
      end
      chk("drain_empty", mv_valid_o, 0);
      chk("drain_ovf_sticky", ovf_o, 1);
      for (int k = 0; k < 3; k++) begin
         slot(14'h060 + 14'(k), 4'(k), 4'(k));
         chk($sformatf("mid_data%0d", k), mv_data_o,
             rec(0, 9'((k + 2) / 4), 9'((k + 2) % 4), 4'(k), 4'(k), 14'h060 + 14'(k)));
         tick();
      end
      sad_en_i = 1'b1; sad_min_i = 14'h070;
      tick();
      sad_en_i = 1'b0;
      frame_start_i = 1'b1;
      tick();
      frame_start_i = 1'b0;
      chk("coll_valid", mv_valid_o, 0);
      chk("coll_ovf", ovf_o, 0);
      tick();
      chk("coll_valid2", mv_valid_o, 0);
      slot(14'h077, 4'd1, 4'd2);
      chk("coll_next", mv_data_o, rec(0, 0, 0, 4'd2, 4'd1, 14'h077));
      tick();
      mv_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         slot(14'h080 + 14'(k), 4'(k), 4'(k));
         tick();
      end
      chk("rstm_queued", mv_data_o, rec(0, 0, 9'd1, 4'd0, 4'd0, 14'h080));
      #2 rst_n = 1'b0;
      #1;
      chk("rstm_valid", mv_valid_o, 0);
      chk("rstm_data", mv_data_o, 0);
      chk("rstm_busy", busy_o, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      fstart();
      mv_ready_i = 1'b1;
      slot(14'h090, 4'd6, 4'd6);
      chk("rstm_skip", mv_valid_o, 0);
      tick();
      chk("rstm_skip2", mv_valid_o, 0);
      slot(14'h091, 4'd4, 4'd4);
      chk("rstm_first", mv_data_o, rec(0, 0, 0, 4'd4, 4'd4, 14'h091));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
